// File: rtl/dual_issue_mem_sequencer.sv
// Memory-stage sequencer for a multi-lane issue bundle: serialises the bundle's
// loads/stores onto a single-port cache in lane order and stalls the pipeline until done.
module dual_issue_mem_sequencer #(
  parameter int LANES = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [LANES-1:0]      mem_read,
  input  logic [LANES-1:0]      mem_write,
  input  logic [LANES*AW-1:0]   addr,
  input  logic [LANES*DW-1:0]   wdata,
  output logic                  stall,
  output logic                  out_valid,
  output logic [LANES*DW-1:0]   rdata,
  output logic                  c_req,
  output logic                  c_wen,
  output logic [AW-1:0]         c_addr,
  output logic [DW-1:0]         c_wdata,
  input  logic                  c_ready,
  input  logic                  c_rvalid,
  input  logic [DW-1:0]         c_rdata,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  // Cache handshake: a request transfers on a cycle where c_req and c_ready are
  // both high; until then c_req, c_addr, c_wen and c_wdata stay constant. Each
  // transferred request gets exactly one c_rvalid beat, consumed only in WAIT.

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LANES-1:0]      pend_q, pend_clr, store_q, mem_lanes;
  logic [LANES*AW-1:0]   addr_q;
  logic [LANES*DW-1:0]   wdata_q;
  logic [LW-1:0]         cur;
  logic                  start;

  assign mem_lanes = mem_read | mem_write;
  assign start     = in_valid && (|mem_lanes);
  assign dbg_state = state_q;

  // Lowest-index pending lane is always the one in flight (program order).
  always_comb begin
    cur = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) cur = LW'(i);
    end
  end

  always_comb begin
    pend_clr = pend_q;
    c_addr   = '0;
    c_wdata  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LW'(i) == cur) begin
        pend_clr[i] = 1'b0;
        c_addr      = addr_q[i*AW +: AW];
        c_wdata     = wdata_q[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    out_valid = 1'b0;
    c_req     = 1'b0;
    c_wen     = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        stall = 1'b1;
        c_req = 1'b1;
        c_wen = store_q[cur];
        if (c_ready) state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (c_rvalid) state_d = (|pend_clr) ? ISSUE : DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Upstream must not see a hold while reset is asserted.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      store_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        pend_q  <= mem_lanes;
        store_q <= mem_write;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == WAIT && c_rvalid) begin
        pend_q <= pend_clr;
        for (int i = 0; i < LANES; i++) begin
          if (LW'(i) == cur && !store_q[i]) rdata[i*DW +: DW] <= c_rdata;
        end
      end
      // A response with nothing outstanding is a cache protocol violation.
      if (c_rvalid && state_q != WAIT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_mem_sequencer.sv
// Self-checking bench for dual_issue_mem_sequencer: the bench acts as the cache and
// predicts request order, load data and completion latency from the lane rules.
module tb_dual_issue_mem_sequencer;
  localparam int LANES = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic [LANES-1:0]    mem_read, mem_write;
  logic [LANES*AW-1:0] addr;
  logic [LANES*DW-1:0] wdata;
  logic                stall, out_valid;
  logic [LANES*DW-1:0] rdata;
  logic                c_req, c_wen;
  logic [AW-1:0]       c_addr;
  logic [DW-1:0]       c_wdata;
  logic                c_ready, c_rvalid;
  logic [DW-1:0]       c_rdata;
  logic                err;
  logic [1:0]          dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_rdata [LANES];
  logic [7:0]    exp_q[$];

  dual_issue_mem_sequencer #(.LANES(LANES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall),
    .out_valid(out_valid), .rdata(rdata), .c_req(c_req), .c_wen(c_wen),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata), .err(err), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_rdata(input string tag);
    for (int i = 0; i < LANES; i++) begin
      n_cmp++;
      if (rdata[i*DW +: DW] !== exp_rdata[i]) begin
        n_fail++;
        $display("FAIL %s rdata[%0d]: got %h expected %h", tag, i, rdata[i*DW +: DW], exp_rdata[i]);
      end
    end
  endtask

  // Drive one bundle and play the cache. Expected latency: 1 capture cycle,
  // per memory lane (ready wait + 1 issue) + (response wait + 1), then 1 DONE cycle.
  task automatic run_bundle(input logic [LANES-1:0] mr, input logic [LANES-1:0] mw,
                            input logic [LANES*AW-1:0] a, input logic [LANES*DW-1:0] wd,
                            input int rdy_lo, input int rdy_hi, input int rsp_lo, input int rsp_hi,
                            input bit fixed, input logic [DW-1:0] fval, input string tag);
    int cyc, exp_cyc, rdy_cnt, rdy_need, rsp_cnt, n_acc, n_exp, lane, rlane;
    bit done, active, resp_pend;
    logic [DW-1:0] rv;
    exp_q.delete();
    for (int i = 0; i < LANES; i++) if (mr[i] | mw[i]) exp_q.push_back(8'(i));
    n_exp = exp_q.size();
    exp_cyc = 2; n_acc = 0; cyc = 0; rdy_cnt = 0; rdy_need = 0; rsp_cnt = 0;
    lane = 0; rlane = 0; done = 0; active = 0; resp_pend = 0;
    @(negedge clk);
    in_valid = 1'b1; mem_read = mr; mem_write = mw; addr = a; wdata = wd;
    c_ready = 1'b0; c_rvalid = 1'b0;
    while (!done && cyc < 400) begin
      #1;
      cyc++;
      if (out_valid === 1'b1) begin
        done = 1;
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b expected 0", tag, stall); end
        n_cmp++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_cyc); end
        n_cmp++;
        if (n_acc != n_exp) begin n_fail++; $display("FAIL %s req_count: got %0d expected %0d", tag, n_acc, n_exp); end
      end else if (stall !== 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL %s stall cycle %0d: got %b expected 1", tag, cyc, stall);
      end
      if (resp_pend) begin
        if (rsp_cnt == 0) begin
          rv = fixed ? fval : DW'($urandom());
          c_rvalid = 1'b1; c_rdata = rv;
          if (!mw[rlane]) exp_rdata[rlane] = rv;
          resp_pend = 0;
        end else rsp_cnt--;
      end
      if (c_req === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0 || resp_pend || c_rvalid) begin
          n_fail++;
          $display("FAIL %s extra_req cycle %0d: got c_req=1 expected 0", tag, cyc);
        end else begin
          lane = int'(exp_q[0]);
          if (c_addr !== a[lane*AW +: AW] || c_wen !== mw[lane] ||
              (mw[lane] && c_wdata !== wd[lane*DW +: DW])) begin
            n_fail++;
            $display("FAIL %s req lane %0d: got addr=%h wen=%b wdata=%h expected addr=%h wen=%b wdata=%h",
                     tag, lane, c_addr, c_wen, c_wdata, a[lane*AW +: AW], mw[lane], wd[lane*DW +: DW]);
          end
          if (!active) begin active = 1; rdy_cnt = 0; rdy_need = $urandom_range(rdy_hi, rdy_lo); end
          if (rdy_cnt == rdy_need) begin
            c_ready = 1'b1; active = 0; rlane = lane; n_acc++;
            void'(exp_q.pop_front());
            resp_pend = 1; rsp_cnt = $urandom_range(rsp_hi, rsp_lo);
            exp_cyc += rdy_need + rsp_cnt + 2;
          end else rdy_cnt++;
        end
      end
      @(negedge clk);
      c_ready = 1'b0; c_rvalid = 1'b0;
      if (done) begin in_valid = 1'b0; mem_read = '0; mem_write = '0; end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: got no out_valid expected out_valid by cycle %0d", tag, exp_cyc);
      in_valid = 1'b0; mem_read = '0; mem_write = '0;
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got out_valid=%b stall=%b expected 0 0", tag, out_valid, stall);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL %s err: got %b expected 0", tag, err); end
    check_rdata(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; mem_read = 2'b01; mem_write = '0;
    addr = '0; wdata = '0; c_ready = 1'b0; c_rvalid = 1'b0; c_rdata = '0;
    for (int i = 0; i < LANES; i++) exp_rdata[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (stall !== 1'b0 || c_req !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b c_req=%b out_valid=%b err=%b state=%0d expected all 0",
               stall, c_req, out_valid, err, dbg_state);
    end
    check_rdata("reset");
    in_valid = 1'b0; mem_read = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    run_bundle(2'b01, 2'b00, {32'h0, 32'h100}, '0, 0, 0, 0, 0, 1'b1, 32'hDEADBEEF, "single_load");
  endtask

  task automatic test_store_load();
    run_bundle(2'b10, 2'b01, {32'h200, 32'h200}, {32'h0, 32'h55}, 0, 0, 0, 0, 1'b1, 32'h55, "store_load");
  endtask

  task automatic test_backpressure();
    run_bundle(2'b10, 2'b00, {32'h340, 32'h0}, '0, 3, 3, 1, 1, 1'b0, '0, "backpressure");
  endtask

  task automatic test_no_mem();
    @(negedge clk);
    in_valid = 1'b1; mem_read = '0; mem_write = '0;
    addr = {$urandom(), $urandom()}; wdata = {$urandom(), $urandom()};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (stall !== 1'b0 || c_req !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL no_mem cycle %0d: got stall=%b c_req=%b out_valid=%b expected 0 0 0", k, stall, c_req, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_rdata("no_mem");
  endtask

  task automatic test_random();
    logic [LANES-1:0] mr, mw;
    for (int n = 0; n < 30; n++) begin
      mr = LANES'($urandom()); mw = LANES'($urandom());
      run_bundle(mr, mw, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 0, 3, 0, 3, 1'b0, '0, "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    in_valid = 1'b1; mem_read = 2'b01; mem_write = '0; addr = {32'h0, 32'h480};
    @(negedge clk);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0; in_valid = 1'b0; mem_read = '0;
    #1;
    n_cmp++;
    if (dbg_state !== 2'd2 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait_pre: got state=%0d stall=%b expected 2 1", dbg_state, stall);
    end
    reset = 1'b1;
    for (int i = 0; i < LANES; i++) exp_rdata[i] = '0;
    #1;
    n_cmp++;
    if (dbg_state !== 2'd0 || c_req !== 1'b0 || stall !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_reset: got state=%0d c_req=%b stall=%b out_valid=%b err=%b expected all 0",
               dbg_state, c_req, stall, out_valid, err);
    end
    check_rdata("mid_wait_reset");
    @(negedge clk);
    reset = 1'b0;
    c_rvalid = 1'b1; c_rdata = 32'hCAFEF00D;
    @(negedge clk);
    c_rvalid = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL stray_rvalid_err: got %b expected 1", err); end
    check_rdata("stray_rvalid");
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b state=%0d expected 1 0", err, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_load();
    test_backpressure();
    test_no_mem();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_mem_sequencer.md
DUAL_ISSUE_MEM_SEQUENCER -- requirements
Module: dual_issue_mem_sequencer

Interface
REQ-001 Parameter LANES, default 2, is the number of issue lanes in one bundle; lane 0 is the oldest instruction.
REQ-002 Parameter AW, default 32, is the address width.
REQ-003 Parameter DW, default 32, is the data width.
REQ-004 clk  in  1  the single clock; every register updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  a memory-stage bundle is present on the inputs.
REQ-007 mem_read  in  LANES  per-lane load request (MemtoReg).
REQ-008 mem_write  in  LANES  per-lane store request (MemWrite).
REQ-009 addr  in  LANES*AW  per-lane address (ALUOut); lane i occupies bits [i*AW +: AW].
REQ-010 wdata  in  LANES*DW  per-lane store data.
REQ-011 stall  out  1  holds the memory-stage bundle and all upstream stages.
REQ-012 out_valid  out  1  one-cycle pulse marking completion of the bundle's memory operations.
REQ-013 rdata  out  LANES*DW  per-lane registered load data.
REQ-014 c_req, c_wen  out  1 each  cache request and its write-enable.
REQ-015 c_addr, c_wdata  out  AW, DW  cache request address and write data.
REQ-016 c_ready  in  1  cache accepts the request this cycle.
REQ-017 c_rvalid, c_rdata  in  1, DW  cache response; one response per accepted request, for loads and stores alike.
REQ-018 err  out  1  sticky protocol-error flag.

Function
REQ-019 Lane i is a memory lane when mem_read[i] or mem_write[i] is set; if both are set, the lane is a store.
REQ-020 The FSM has four states, IDLE, ISSUE, WAIT and DONE, and resets to IDLE.
REQ-021 IDLE:
  - if in_valid is high and at least one memory lane exists: capture the pending mask, addr, wdata and the per-lane store flags; go to ISSUE.
  - otherwise: remain in IDLE with stall=0.
REQ-022 In IDLE, stall is combinationally high in the capture cycle.
REQ-023 In ISSUE and WAIT, stall is held high.
REQ-024 ISSUE drives c_req=1 for the lowest-index pending lane, using the captured address, data and store flag; on c_ready=1 it goes to WAIT.
REQ-025 ISSUE holds c_req high with stable c_addr, c_wen and c_wdata until c_ready is seen.
REQ-026 c_req is 0 in every state other than ISSUE.
REQ-027 At most one cache request is outstanding at any time.
REQ-028 WAIT on c_rvalid=1:
  - write c_rdata into that lane's rdata slot if the lane is a load;
  - clear the lane's pending bit;
  - go to ISSUE if pending bits remain, otherwise go to DONE.
REQ-029 Lanes are serviced strictly in ascending index order, which preserves program order for a same-address store/load pair within a bundle.
REQ-030 DONE drives out_valid=1 and stall=0 for exactly one cycle and ignores all inputs; the next state is IDLE.
REQ-031 rdata slots of store lanes and non-memory lanes retain their previous values.
REQ-032 Every rdata slot holds its value until overwritten by a later load response.
REQ-033 Minimum latency for a single-lane load, with c_ready=1 and the response one cycle after acceptance, is four cycles: capture, issue, response, DONE. stall is high for the first three of these cycles.
REQ-034 Each additional memory lane adds at least two cycles.
REQ-035 c_rvalid outside WAIT is ignored for data and sets err=1.
REQ-036 err stays set until reset.

Reset
REQ-037 Asserting reset, including mid-operation, immediately forces:
  - state to IDLE;
  - c_req=0, out_valid=0 and err=0;
  - every rdata slot and the pending mask to 0.
  Any outstanding cache transaction is abandoned.
REQ-038 While reset is high, stall is 0.
REQ-039 After reset deasserts, the first rising edge behaves as IDLE.

Verification
REQ-040 Lane 0 load from 0x100, lane 1 has no memory op, c_ready=1, c_rdata=0xDEADBEEF one cycle later -> exactly one request (c_wen=0, c_addr=0x100); stall high for 3 cycles; out_valid pulse; rdata lane 0 = 0xDEADBEEF.
REQ-041 Lane 0 store 0x55 to 0x200, lane 1 load from 0x200, cache returns 0x55 -> the store is issued before the load; rdata lane 1 = 0x55; lane 0 slot unchanged; total 6 cycles to out_valid.
REQ-042 Load with c_ready held low 3 cycles -> c_req, c_addr and c_wen stable across all ISSUE cycles; stall high throughout; exactly one accepted request.
REQ-043 in_valid=1 with no memory lanes -> stall=0, no c_req, no out_valid, rdata unchanged.
REQ-044 Reset asserted in WAIT with c_rvalid arriving afterwards -> immediate IDLE, c_req=0, rdata=0, err=0; the post-reset c_rvalid sets err=1.
